// File: rtl/ifetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifetch_pkg                                             |
// | Description : Shared definitions for the instruction-fetch           |
// |               controller: default widths, FSM state encoding and     |
// |               the HALT opcode.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ifetch_pkg;

    // Default instruction address / word widths
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Fetch FSM state encoding
    localparam int               ST_W    = 3;
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD = 3'd3;
    localparam logic [ST_W-1:0] ST_HALT = 3'd4;

    // Top opcode nibble that stops fetching when halt detection is built in
    localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/ifetch_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifetch_hold_reg                                        |
// | Description : Width-parameterised holding register made of per-bit  |
// |               dff cells with synchronous reset and write enable.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ifetch_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            // One dff cell per bit: clear on reset, load when enabled
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q[gi] <= 1'b0;
                end else if (i_wen) begin
                    r_q[gi] <= i_d[gi];
                end
            end
        end
    endgenerate

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifetch_ctrl                                            |
// | Description : Instruction-fetch controller. Issues one read per      |
// |               instruction to a multi-cycle memory, holds the word    |
// |               until decode accepts it, then pulses pc_wen. Handles   |
// |               branch-flush redirects. Optional HALT detection is     |
// |               built in when IFETCH_HALT_DETECT_EN is defined.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_val,
    output logic              pc_wen,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              halted
);

    logic [ST_W-1:0]   r_state;
    logic              r_drop;     // in-flight word must be discarded

    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_inst_q;
    logic [ADDR_W-1:0] w_inst_pc_q;
    logic              w_capture;
    logic              w_accept;
    logic              w_is_halt;

    // A returning word is kept only in WAIT, with no pending or concurrent flush
    assign w_capture = (r_state == ST_WAIT) && mem_data_valid && !r_drop && !flush;

    // Decode takes the held word; a flush in the same cycle cancels it
    assign w_accept = (r_state == ST_HOLD) && inst_ready && !flush;

`ifdef IFETCH_HALT_DETECT_EN
    assign w_is_halt = (w_inst_q[DATA_W-1 -: 4] == HALT_OPCODE);
`else
    assign w_is_halt = 1'b0;
`endif

    // Address of the outstanding request, captured while it is issued
    ifetch_hold_reg #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk   (clk),
        .rst   (rst),
        .i_wen (r_state == ST_REQ),
        .i_d   (pc_val),
        .o_q   (w_addr_q)
    );

    // Returned instruction word presented to IF/ID
    ifetch_hold_reg #(.WIDTH(DATA_W)) u_inst_reg (
        .clk   (clk),
        .rst   (rst),
        .i_wen (w_capture),
        .i_d   (mem_data),
        .o_q   (w_inst_q)
    );

    // Address that belongs to the held instruction word
    ifetch_hold_reg #(.WIDTH(ADDR_W)) u_inst_pc_reg (
        .clk   (clk),
        .rst   (rst),
        .i_wen (w_capture),
        .i_d   (w_addr_q),
        .o_q   (w_inst_pc_q)
    );

    // Fetch sequencing: request, wait for memory, hold for decode, redirect on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    // The read has already gone out; a flush only marks it stale
                    r_state <= ST_WAIT;
                    r_drop  <= flush;
                end
                ST_WAIT: begin
                    if (mem_data_valid) begin
                        r_state <= (r_drop || flush) ? ST_REQ : ST_HOLD;
                        r_drop  <= 1'b0;
                    end else if (flush) begin
                        r_drop  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        r_state <= ST_REQ;
`ifdef IFETCH_HALT_DETECT_EN
                    end else if (inst_ready) begin
                        r_state <= w_is_halt ? ST_HALT : ST_REQ;
`else
                    end else if (inst_ready) begin
                        r_state <= ST_REQ;
`endif
                    end
                end
`ifdef IFETCH_HALT_DETECT_EN
                ST_HALT: begin
                    if (flush) begin
                        r_state <= ST_REQ;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced to zero while reset is asserted so nothing leaks mid-reset
    assign mem_rd_en  = !rst && (r_state == ST_REQ);
    assign mem_addr   = mem_rd_en ? pc_val : '0;
    assign inst_valid = !rst && (r_state == ST_HOLD);
    assign pc_wen     = !rst && w_accept && !w_is_halt;
    assign inst       = rst ? '0 : w_inst_q;
    assign inst_pc    = rst ? '0 : w_inst_pc_q;

`ifdef IFETCH_HALT_DETECT_EN
    assign halted = !rst && (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that reads the instruction memory at the address held in the PC register. It sits between the PC register and the IF/ID pipeline latch. It issues one read per instruction to a multi-cycle memory, holds the returned word until the decode stage accepts it, and then tells the PC-next mux to advance. It also handles branch-flush redirects and, optionally, HALT detection.

## Interface
- ADDR_W, 16, instruction address width
- DATA_W, 16, instruction word width
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pc_val  in  ADDR_W  current PC register output
- pc_wen  out  1  one-cycle pulse; PC-next mux selects PC+2 for the next edge
- flush  in  1  branch redirect; PC-next mux loads the target on the same edge
- mem_rd_en  out  1  one-cycle read strobe to instruction memory
- mem_addr  out  ADDR_W  read address, valid while mem_rd_en=1
- mem_data  in  DATA_W  returned instruction word
- mem_data_valid  in  1  mem_data valid this cycle
- inst  out  DATA_W  held instruction to IF/ID
- inst_pc  out  ADDR_W  address of the held instruction
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  IF/ID accepts this cycle
- halted  out  1  fetch stopped on HALT (tied 0 without the macro)

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT (HALT exists only with the macro).
- IDLE: entered on reset; unconditionally goes to REQ on the next cycle.
- REQ: lasts exactly 1 cycle.
  - mem_rd_en=1 and mem_addr=pc_val (combinational from state).
  - pc_val is captured into the address register.
  - Next state: WAIT.
- WAIT: hold until mem_data_valid=1.
  - On mem_data_valid, capture mem_data into inst and the address register into inst_pc.
  - Next state: HOLD.
- HOLD: inst_valid=1.
  - When inst_ready=1: pc_wen=1 for that cycle, then go to REQ. The PC has advanced by the time REQ samples it.
- Flush:
  - In WAIT: set a drop flag. The next mem_data_valid is discarded (no HOLD); go to REQ.
  - In REQ: the request still issues; go to WAIT with drop set.
  - In HOLD: clear inst_valid; go to REQ. No pc_wen, even if inst_ready=1 that cycle.
  - In IDLE: ignored.
- mem_data_valid is ignored outside WAIT. This covers stale data after reset or after a discard.
- Simultaneous mem_data_valid and flush in WAIT: the data is discarded.
- inst and inst_pc are held stable for as long as inst_valid=1 and inst_ready=0.

## Timing
- Reset values: state IDLE; drop=0.
  - Outputs: pc_wen=0, mem_rd_en=0, mem_addr=0, inst=0, inst_pc=0, inst_valid=0, halted=0.
- Reset mid-operation (any state): return to IDLE the next cycle and clear all registers. No pc_wen is issued.
- With memory latency L (mem_data_valid L cycles after mem_rd_en) and inst_ready held at 1:
  - REQ at cycle t.
  - Data captured at t+L.
  - inst_valid at t+L+1; pc_wen at t+L+1.
  - Next REQ at t+L+2.
  - For L=4, one instruction every 6 cycles.
- pc_wen is never high in two consecutive cycles, and never high outside HOLD.
- A flush that arrives while in WAIT delays the next REQ until the in-flight word returns.

## Configuration
- IFETCH_HALT_DETECT_EN defined:
  - A captured word with inst[15:12]==4'hF is delivered normally.
  - On its acceptance: no pc_wen; go to HALT. HALT issues no further requests and holds halted=1.
  - Only rst or flush leaves HALT. Flush clears halted and goes to REQ.
- Macro undefined: no HALT state; halted is tied to 0; the opcode is not inspected.

## Structure
- Shared package ifetch_pkg holds:
  - the state enumeration;
  - HALT_OPCODE = 4'hF;
  - default ADDR_W/DATA_W.
- One sub-module, ifetch_hold_reg: a width-parameterised register built from the codebase dff cell with wen and rst. It is instantiated for inst, inst_pc and the address capture.

## Test plan
- Reset then run: pc_val=16'h0000, L=4, inst_ready=1, mem returns 16'h1234.
  - mem_rd_en at cycle 1; inst_valid with inst=16'h1234 and inst_pc=0 at cycle 6; pc_wen at cycle 6.
- Back-pressure: inst_ready=0 for 3 cycles during HOLD.
  - inst is stable; pc_wen=0 throughout; pc_wen=1 exactly in the cycle inst_ready rises.
- Flush in WAIT: flush at cycle 3.
  - Returned word 16'hDEAD is never presented; REQ reissues with the new pc_val=16'h0040; next inst_pc=16'h0040.
- Flush and inst_ready together in HOLD.
  - inst_valid drops; pc_wen=0; REQ follows the next cycle.
- Reset in WAIT: rst at cycle 3, mem_data_valid at cycle 5.
  - Data is ignored; all outputs are 0 during reset; the new REQ is at pc_val.
- With IFETCH_HALT_DETECT_EN: mem returns 16'hF000.
  - Delivered once; then halted=1, no mem_rd_en for 20 cycles, no pc_wen.
  - A flush restarts fetch.
